// File: rtl/slide_pkg.sv
// Shared types and constants for the sliding-window signed-digit recoder.
package slide_pkg;

  localparam int SLIDE_N_BITS = 256;
  localparam int SLIDE_WIN    = 5;
  localparam int SLIDE_DW     = 5;

  typedef logic signed [SLIDE_DW-1:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SCAN_I  = 3'd2,
    ST_SCAN_B  = 3'd3,
    ST_COMBINE = 3'd4,
    ST_CARRY   = 3'd5,
    ST_EMIT    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Largest digit magnitude for a window of win bits.
  function automatic int dmax_f(input int win);
    return (32'sd1 << (win - 32'sd1)) - 32'sd1;
  endfunction

  // Furthest neighbour a digit may absorb.
  function automatic int bmax_f(input int win);
    return win + 32'sd1;
  endfunction

  // Signed width wide enough for r[i] +/- (r[i+b] << BMAX).
  function automatic int comb_w_f(input int dw, input int win);
    return dw + bmax_f(win) + 32'sd1;
  endfunction

  localparam int SLIDE_COMB_W = comb_w_f(SLIDE_DW, SLIDE_WIN);

endpackage

// File: rtl/slide_digit_store.sv
// Recoder digit store: N_BITS signed digits, parallel bit load, two shared
// read/write address ports (i and i+b, or the carry index).
module slide_digit_store
  import slide_pkg::*;
#(
  parameter  int N_BITS = SLIDE_N_BITS,
  parameter  int DW     = SLIDE_DW,
  localparam int AW     = $clog2(N_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [N_BITS-1:0]    load_bits,
  input  logic [AW-1:0]        addr_a,
  input  logic [AW-1:0]        addr_b,
  output logic signed [DW-1:0] rd_a,
  output logic signed [DW-1:0] rd_b,
  input  logic                 we_a,
  input  logic signed [DW-1:0] wd_a,
  input  logic                 we_b,
  input  logic signed [DW-1:0] wd_b
);

  localparam int DEPTH = 1 << AW;
  localparam logic signed [DW-1:0] DIG_ONE = DW'(32'sd1);

  logic signed [DW-1:0] mem_r [DEPTH];

  assign rd_a = mem_r[addr_a];
  assign rd_b = mem_r[addr_b];

  // Digit array: cleared on reset, reloaded from the scalar bits on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_r[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < N_BITS; k++) mem_r[k] <= load_bits[k] ? DIG_ONE : '0;
      for (int k = N_BITS; k < DEPTH; k++) mem_r[k] <= '0;
    end else begin
      if (we_a) mem_r[addr_a] <= wd_a;
      if (we_b) mem_r[addr_b] <= wd_b;
    end
  end

endmodule

// File: rtl/slide_wnaf_recoder.sv
// Sliding-window signed-digit recoder (ref10 slide() generalised), digits streamed MSB-first.
// Build option SLIDE_SKIP_LEADING_EN: emission starts at the highest non-zero digit.
module slide_wnaf_recoder
  import slide_pkg::*;
#(
  parameter int N_BITS = SLIDE_N_BITS,
  parameter int WIN    = SLIDE_WIN,
  parameter int DW     = SLIDE_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_BITS-1:0]         scalar,
  output logic                      busy,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic signed [DW-1:0]      dout_digit,
  output logic [$clog2(N_BITS)-1:0] dout_idx,
  output logic                      dout_last,
  output logic                      done,
  output logic                      carry_lost
);

  localparam int AW   = $clog2(N_BITS);
  localparam int BMAX = bmax_f(WIN);
  localparam int BW   = $clog2(BMAX + 2);
  localparam int CW   = comb_w_f(DW, WIN);
  localparam logic [AW-1:0]        LAST_I  = AW'(N_BITS - 1);
  localparam logic [AW:0]          N_C     = (AW+1)'(N_BITS);
  localparam logic [BW-1:0]        BMAX_C  = BW'(BMAX);
  localparam logic signed [CW-1:0] DMAX_C  = CW'(dmax_f(WIN));
  localparam logic signed [CW-1:0] NDMAX_C = CW'(-dmax_f(WIN));
  localparam logic signed [DW-1:0] DIG_ONE = DW'(32'sd1);

  state_t state_r, state_n;
  logic [AW-1:0] i_r, i_n;
  logic [BW-1:0] b_r, b_n;
  logic [AW:0]   k_r, k_n;
  logic [AW:0]   ib_s;
  logic [AW-1:0] addr_a_s, addr_b_s, emit_addr_s, emit_top_s;
  logic signed [DW-1:0] rd_a_s, rd_b_s, wd_a_s, wd_b_s;
  logic signed [CW-1:0] a_ext_s, sh_s, sum_s, dif_s;
  logic load_s, we_a_s, we_b_s, adv_s, set_lost_s, emit_load_s, emit_end_s;

  logic busy_r, valid_r, last_r, done_r, lost_r;
  logic signed [DW-1:0] digit_r;
  logic [AW-1:0] idx_r;

  assign ib_s     = {1'b0, i_r} + (AW+1)'(b_r);
  assign a_ext_s  = CW'(rd_a_s);
  assign sh_s     = CW'(rd_b_s) <<< b_r;
  assign sum_s    = a_ext_s + sh_s;
  assign dif_s    = a_ext_s - sh_s;

  // Port A follows i while recoding and the emit pointer afterwards; port B is i+b or the carry index.
  assign emit_addr_s = valid_r ? (idx_r - AW'(1)) : emit_top_s;
  assign addr_a_s    = (state_r == ST_EMIT) ? emit_addr_s : i_r;
  assign addr_b_s    = (state_r == ST_CARRY) ? k_r[AW-1:0] : ib_s[AW-1:0];

  slide_digit_store #(.N_BITS(N_BITS), .DW(DW)) u_store (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_bits (scalar),
    .addr_a    (addr_a_s),
    .addr_b    (addr_b_s),
    .rd_a      (rd_a_s),
    .rd_b      (rd_b_s),
    .we_a      (we_a_s),
    .wd_a      (wd_a_s),
    .we_b      (we_b_s),
    .wd_b      (wd_b_s)
  );

`ifdef SLIDE_SKIP_LEADING_EN
  logic [AW-1:0] top_r;

  // r[i] is final once i advances, so the last non-zero index passed is the top digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_r <= '0;
    end else if (load_s) begin
      top_r <= '0;
    end else if (adv_s && (rd_a_s != '0)) begin
      top_r <= i_r;
    end else begin
      top_r <= top_r;
    end
  end

  assign emit_top_s = top_r;
`else
  assign emit_top_s = LAST_I;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_n;
  end

  // Next state, index updates and store write controls.
  always_comb begin
    state_n     = state_r;
    i_n         = i_r;
    b_n         = b_r;
    k_n         = k_r;
    load_s      = 1'b0;
    we_a_s      = 1'b0;
    wd_a_s      = '0;
    we_b_s      = 1'b0;
    wd_b_s      = '0;
    adv_s       = 1'b0;
    set_lost_s  = 1'b0;
    emit_load_s = 1'b0;
    emit_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_n = ST_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        i_n     = '0;
        state_n = ST_SCAN_I;
      end
      ST_SCAN_I: begin
        if (rd_a_s == '0) begin
          adv_s = 1'b1;
        end else begin
          b_n     = BW'(1'b1);
          state_n = ST_SCAN_B;
        end
      end
      ST_SCAN_B: begin
        if ((ib_s >= N_C) || (b_r > BMAX_C)) begin
          adv_s = 1'b1;
        end else if (rd_b_s == '0) begin
          b_n = b_r + BW'(1'b1);
        end else begin
          state_n = ST_COMBINE;
        end
      end
      ST_COMBINE: begin
        if (sum_s <= DMAX_C) begin
          we_a_s  = 1'b1;
          wd_a_s  = sum_s[DW-1:0];
          we_b_s  = 1'b1;
          b_n     = b_r + BW'(1'b1);
          state_n = ST_SCAN_B;
        end else if (dif_s >= NDMAX_C) begin
          we_a_s  = 1'b1;
          wd_a_s  = dif_s[DW-1:0];
          k_n     = ib_s;
          state_n = ST_CARRY;
        end else begin
          adv_s = 1'b1;
        end
      end
      ST_CARRY: begin
        if (k_r >= N_C) begin
          set_lost_s = 1'b1;
          b_n        = b_r + BW'(1'b1);
          state_n    = ST_SCAN_B;
        end else if (rd_b_s == '0) begin
          we_b_s  = 1'b1;
          wd_b_s  = DIG_ONE;
          b_n     = b_r + BW'(1'b1);
          state_n = ST_SCAN_B;
        end else begin
          we_b_s = 1'b1;
          k_n    = k_r + (AW+1)'(1'b1);
        end
      end
      ST_EMIT: begin
        if (valid_r) begin
          if (dout_ready) begin
            if (idx_r == '0) begin
              emit_end_s = 1'b1;
              state_n    = ST_DONE;
            end else begin
              emit_load_s = 1'b1;
            end
          end else begin
            emit_load_s = 1'b0;
          end
        end else begin
          emit_load_s = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (adv_s) begin
      if (i_r == LAST_I) begin
        state_n = ST_EMIT;
      end else begin
        i_n     = i_r + AW'(1'b1);
        state_n = ST_SCAN_I;
      end
    end else begin
      i_n = i_n;
    end
  end

  // Datapath indices and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_r     <= '0;
      b_r     <= '0;
      k_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      lost_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      digit_r <= '0;
      idx_r   <= '0;
    end else begin
      i_r    <= i_n;
      b_r    <= b_n;
      k_r    <= k_n;
      busy_r <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done_r <= (state_n == ST_DONE);
      if (load_s)          lost_r <= 1'b0;
      else if (set_lost_s) lost_r <= 1'b1;
      else                 lost_r <= lost_r;
      if (emit_load_s) begin
        valid_r <= 1'b1;
        digit_r <= rd_a_s;
        idx_r   <= emit_addr_s;
        last_r  <= (emit_addr_s == '0);
      end else if (emit_end_s) begin
        valid_r <= 1'b0;
        digit_r <= '0;
        idx_r   <= '0;
        last_r  <= 1'b0;
      end else begin
        valid_r <= valid_r;
        digit_r <= digit_r;
        idx_r   <= idx_r;
        last_r  <= last_r;
      end
    end
  end

  assign busy       = busy_r;
  assign dout_valid = valid_r;
  assign dout_digit = digit_r;
  assign dout_idx   = idx_r;
  assign dout_last  = last_r;
  assign done       = done_r;
  assign carry_lost = lost_r;

endmodule

// File: tb/tb_slide_wnaf_recoder.sv
// Directed bench for slide_wnaf_recoder: hand-computed digit vectors plus a ref10 slide() model for random scalars.
module tb_slide_wnaf_recoder;

  localparam int NB = 256;
  localparam int DW = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [NB-1:0]        scalar = '0;
  logic                 busy;
  logic                 dout_valid;
  logic                 dout_ready = 1'b0;
  logic signed [DW-1:0] dout_digit;
  logic [7:0]           dout_idx;
  logic                 dout_last;
  logic                 done;
  logic                 carry_lost;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_r [NB];
  bit exp_lost;

  slide_wnaf_recoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .scalar     (scalar),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_digit (dout_digit),
    .dout_idx   (dout_idx),
    .dout_last  (dout_last),
    .done       (done),
    .carry_lost (carry_lost)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < NB; k++) exp_r[k] = 0;
    exp_lost = 1'b0;
  endtask

  // Straight transcription of ref10 slide() with window 5.
  task automatic slide_model(input logic [NB-1:0] s);
    for (int k = 0; k < NB; k++) exp_r[k] = s[k] ? 1 : 0;
    exp_lost = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (exp_r[i] != 0) begin
        for (int b = 1; b <= 6 && i + b < NB; b++) begin
          if (exp_r[i+b] != 0) begin
            if (exp_r[i] + (exp_r[i+b] << b) <= 15) begin
              exp_r[i] += exp_r[i+b] << b;
              exp_r[i+b] = 0;
            end else if (exp_r[i] - (exp_r[i+b] << b) >= -15) begin
              int k;
              exp_r[i] -= exp_r[i+b] << b;
              for (k = i + b; k < NB; k++) begin
                if (exp_r[k] == 0) begin
                  exp_r[k] = 1;
                  break;
                end
                exp_r[k] = 0;
              end
              if (k == NB) exp_lost = 1'b1;
            end else begin
              break;
            end
          end
        end
      end
    end
  endtask

  task automatic run_vec(input string name, input logic [NB-1:0] s, input bit bp, input bit poke);
    int exp_first, nexp, n_got, cyc;
    bit holding, fin, rdy;
    logic signed [DW-1:0] hold_d;
    logic [7:0] hold_i;
`ifdef SLIDE_SKIP_LEADING_EN
    exp_first = 0;
    for (int k = 0; k < NB; k++) if (exp_r[k] != 0) exp_first = k;
`else
    exp_first = NB - 1;
`endif
    @(negedge clk);
    scalar = s; start = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; scalar = '0;
    check_eq({name, ".busy"}, busy, 1);
    nexp = exp_first; n_got = 0; cyc = 0; holding = 1'b0; fin = 1'b0;
    hold_d = '0; hold_i = '0;
    while (!fin && cyc < 8000) begin
      start = 1'b0;
      if (poke && cyc == 4) begin
        check_eq({name, ".poke_busy"}, busy, 1);
        scalar = ~s; start = 1'b1;
      end
      if (done) begin
        fin = 1'b1;
        check_eq({name, ".lost"}, carry_lost, exp_lost);
        check_eq({name, ".count"}, n_got, exp_first + 1);
        check_eq({name, ".valid_at_done"}, dout_valid, 0);
        scalar = ~s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; scalar = '0;
        check_eq({name, ".start_in_done"}, busy, 0);
      end else begin
        if (dout_valid) begin
          if (holding) begin
            check_eq({name, ".hold_digit"}, dout_digit, hold_d);
            check_eq({name, ".hold_idx"}, dout_idx, hold_i);
          end
          rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
          dout_ready = rdy;
          if (rdy) begin
            check_eq({name, ".idx"}, dout_idx, nexp);
            check_eq({name, ".digit"}, dout_digit, (nexp >= 0) ? exp_r[nexp] : 99);
            check_eq({name, ".last"}, dout_last, (nexp == 0) ? 1 : 0);
            n_got++; nexp--; holding = 1'b0;
          end else begin
            holding = 1'b1; hold_d = dout_digit; hold_i = dout_idx;
          end
        end else begin
          dout_ready = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) begin
      check_eq({name, ".timeout"}, 0, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] s;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.valid", dout_valid, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.lost", carry_lost, 0);
    check_eq("rst.last", dout_last, 0);
    check_eq("rst.digit", dout_digit, 0);
    rst = 1'b1;
    @(negedge clk);

    clear_exp(); exp_r[0] = 1;
    run_vec("one", 256'h1, 1'b0, 1'b1);
    clear_exp(); exp_r[0] = -1; exp_r[5] = 1;
    run_vec("x1f", 256'h1F, 1'b1, 1'b0);
    clear_exp(); exp_r[0] = 3;
    run_vec("three", 256'h3, 1'b0, 1'b0);
    clear_exp(); exp_r[0] = 7;
    run_vec("seven", 256'h7, 1'b1, 1'b0);
    clear_exp(); exp_r[0] = 15;
    run_vec("dmax", 256'hF, 1'b0, 1'b0);
    clear_exp(); exp_r[0] = 9;
    run_vec("x09", 256'h9, 1'b0, 1'b0);
    clear_exp(); exp_r[0] = -15; exp_r[5] = 1;
    run_vec("neg_dmax", 256'h11, 1'b1, 1'b0);
    clear_exp(); exp_r[0] = 1; exp_r[5] = 1;
    run_vec("break5", 256'h21, 1'b0, 1'b0);
    clear_exp(); exp_r[0] = 1; exp_r[6] = 1;
    run_vec("bmax", 256'h41, 1'b0, 1'b0);
    clear_exp();
    run_vec("zero", 256'h0, 1'b0, 1'b0);
    clear_exp(); exp_r[0] = -1; exp_lost = 1'b1;
    s = '1;
    run_vec("ones", s, 1'b1, 1'b0);
    clear_exp(); exp_r[251] = -15; exp_lost = 1'b1;
    s = '0; s[255] = 1'b1; s[251] = 1'b1;
    run_vec("top_carry", s, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      for (int w = 0; w < 8; w++) s[w*32 +: 32] = $urandom;
      s[255] = 1'b0;
      slide_model(s);
      run_vec("rand", s, 1'b1, 1'b0);
    end

    // Abort a long carry chain with reset, then recode a fresh scalar.
    @(negedge clk);
    scalar = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; scalar = '0;
    repeat (30) @(negedge clk);
    check_eq("mid.busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check_eq("mid.busy", busy, 0);
    check_eq("mid.valid", dout_valid, 0);
    check_eq("mid.done", done, 0);
    check_eq("mid.lost", carry_lost, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid.after_busy", busy, 0);
    check_eq("mid.after_done", done, 0);
    clear_exp(); exp_r[0] = -1; exp_r[5] = 1;
    run_vec("after_rst", 256'h1F, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
